// File: rtl/muldiv_pkg.sv
// Shared op-code encoding and FSM state type for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_t;

  // Codes 0..3 are the multi-cycle arithmetic ops.
  function automatic logic is_arith(input logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 2*WIDTH+1 bit accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_in,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [2*WIDTH:0] acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH:0] shifted;

  always_comb begin
    sum     = acc_in[2*WIDTH:WIDTH] + (acc_in[0] ? {1'b0, operand} : '0);
    shifted = {acc_in[2*WIDTH-1:0], 1'b0};
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, operand};
    acc_out = shifted;
    if (is_div) begin
      // Upper part is the partial remainder, lower part collects quotient bits.
      if (shifted[2*WIDTH:WIDTH] >= {1'b0, operand})
        acc_out = {trial, shifted[WIDTH-1:1], 1'b1};
    end else begin
      // Lower part starts as the multiplier and is consumed LSB first.
      acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and flush support.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_next;
  logic [WIDTH-1:0] operand;
  logic             is_div;
  logic             neg_main;
  logic             neg_rem;

  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] res_prod;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_r;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc),
    .operand (operand),
    .is_div  (is_div),
    .acc_out (acc_next)
  );

  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    // Negating MIN yields MIN, which is the correct unsigned magnitude.
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    res_prod  = neg_main ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    res_q     = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    res_r     = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            if (is_arith(op)) begin
              is_div <= op[1];
              count  <= CW'(WIDTH);
              busy   <= 1'b1;
              state  <= ST_RUN;
              if (op[1]) begin
                acc      <= {{(WIDTH+1){1'b0}}, a_mag};
                operand  <= b_mag;
                // A zero divisor leaves an all-ones quotient unnegated.
                neg_main <= (a_neg ^ b_neg) && (b != '0);
                neg_rem  <= a_neg;
              end else begin
                acc      <= {{(WIDTH+1){1'b0}}, b_mag};
                operand  <= a_mag;
                neg_main <= a_neg ^ b_neg;
                neg_rem  <= 1'b0;
              end
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            acc   <= acc_next;
            count <= count - CW'(1);
            if (count == CW'(1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= res_r;
              lo <= res_q;
            end else begin
              hi <= res_prod[2*WIDTH-1:WIDTH];
              lo <= res_prod[WIDTH-1:0];
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
